// File: rtl/prog_cntr_sel_ctrl.sv
// Program-counter source select controller with a return-address stack
// and single-level (non-nesting) interrupt handling.
module prog_cntr_sel_ctrl #(
    parameter int STACK_DEPTH = 8,
    parameter int ADDR_W      = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic              call,
    input  logic              ret,
    input  logic              reti,
    input  logic              int_req,
    input  logic [ADDR_W-1:0] call_ret_addr,
    input  logic [ADDR_W-1:0] int_ret_addr,
    output logic [3:0]        sel_signals,
    output logic [ADDR_W-1:0] ret_addr,
    output logic              int_enable,
    output logic              int_ack,
    output logic              stack_overflow,
    output logic              stack_underflow
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ISR = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              int_ack_q, int_ack_d;
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

    logic              active;
    logic              int_take;
    logic              do_push;
    logic              do_pop;
    logic              push_ok;
    logic [ADDR_W-1:0] push_data;
    logic [CNT_W-1:0]  count_m1;
    logic [PTR_W-1:0]  wr_idx;
    logic [PTR_W-1:0]  rd_idx;

    // Decode this cycle's stack/interrupt actions; interrupt entry pre-empts everything else
    always_comb begin
        active    = !reset && !stall;
        int_take  = int_req && (state_q == ST_RUN) && active;
        do_pop    = active && !int_take && (ret || reti);
        do_push   = int_take || (active && call && !(ret || reti));
        push_data = int_take ? int_ret_addr : call_ret_addr;
        push_ok   = do_push && (count_q != CNT_FULL);
        count_m1  = count_q - CNT_ONE;
        wr_idx    = count_q[PTR_W-1:0];
        rd_idx    = count_m1[PTR_W-1:0];
    end

    // PC source priority: reset/stall, interrupt, return, call/branch, sequential
    always_comb begin
        sel_signals = 4'b0010;
        if (reset || stall) begin
            sel_signals = 4'b0010;
        end else if (int_take) begin
            sel_signals = 4'b0100;
        end else if (ret || reti) begin
            sel_signals = 4'b1000;
        end else if (call || branch_taken) begin
            sel_signals = 4'b0001;
        end
    end

    // Stack occupancy and sticky error flags; a full push or empty pop leaves count untouched
    always_comb begin
        count_d   = count_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        int_ack_d = int_take;
        if (do_push) begin
            if (count_q == CNT_FULL) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end
        if (do_pop) begin
            if (count_q == '0) begin
                unf_d = 1'b1;
            end else begin
                count_d = count_m1;
            end
        end
    end

    // FSM next state: leave RUN only on interrupt entry, leave ISR only on an unstalled reti
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (int_take) state_d = ST_ISR;
            ST_ISR:  if (reti && active) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // FSM outputs: interrupts are masked while servicing one
    always_comb begin
        int_enable = (state_q == ST_RUN);
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Stack pointer, error flags and interrupt acknowledge registers
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            int_ack_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            int_ack_q <= int_ack_d;
        end
    end

    // Stack storage; entries are not cleared by reset, the count defines validity
    always_ff @(posedge clock) begin
        if (push_ok) begin
            stack_mem[wr_idx] <= push_data;
        end
    end

    // Top-of-stack view; reads zero when the stack is empty
    always_comb begin
        ret_addr = (count_q != '0) ? stack_mem[rd_idx] : '0;
    end

    assign int_ack         = int_ack_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_prog_cntr_sel_ctrl.sv
// Directed bench for prog_cntr_sel_ctrl: hand-computed expectations per step.
module tb_prog_cntr_sel_ctrl;

    localparam int ADDR_W = 14;

    logic              clock = 1'b0;
    logic              reset;
    logic              stall;
    logic              branch_taken;
    logic              call;
    logic              ret;
    logic              reti;
    logic              int_req;
    logic [ADDR_W-1:0] call_ret_addr;
    logic [ADDR_W-1:0] int_ret_addr;
    logic [3:0]        sel_signals;
    logic [ADDR_W-1:0] ret_addr;
    logic              int_enable;
    logic              int_ack;
    logic              stack_overflow;
    logic              stack_underflow;

    int n_cmp  = 0;
    int n_fail = 0;

    prog_cntr_sel_ctrl #(.STACK_DEPTH(8), .ADDR_W(ADDR_W)) dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .call            (call),
        .ret             (ret),
        .reti            (reti),
        .int_req         (int_req),
        .call_ret_addr   (call_ret_addr),
        .int_ret_addr    (int_ret_addr),
        .sel_signals     (sel_signals),
        .ret_addr        (ret_addr),
        .int_enable      (int_enable),
        .int_ack         (int_ack),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        call = 1'b0; ret = 1'b0; reti = 1'b0; int_req = 1'b0;
    endtask

    // advance one clock; sample 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        idle_inputs();
        call_ret_addr = '0;
        int_ret_addr  = '0;
        reset = 1'b1;
        #1;
        check_val("rst_sel", {28'd0, sel_signals}, 32'h2);
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        check_val("rst_ret_addr", {18'd0, ret_addr}, 32'h0);
        check_val("rst_int_en", {31'd0, int_enable}, 32'h1);
        check_val("rst_int_ack", {31'd0, int_ack}, 32'h0);
        check_val("rst_ovf", {31'd0, stack_overflow}, 32'h0);
        check_val("rst_unf", {31'd0, stack_underflow}, 32'h0);

        // branch alone: select branch target, no push
        branch_taken = 1'b1; call_ret_addr = 14'h0777;
        #1;
        check_val("br_sel", {28'd0, sel_signals}, 32'h1);
        cyc();
        idle_inputs();
        #1;
        check_val("br_no_push", {18'd0, ret_addr}, 32'h0);

        // call then ret two cycles later
        call = 1'b1; call_ret_addr = 14'h0123;
        #1;
        check_val("call_sel", {28'd0, sel_signals}, 32'h1);
        cyc();
        idle_inputs();
        #1;
        check_val("call_top", {18'd0, ret_addr}, 32'h0123);
        check_val("idle_sel", {28'd0, sel_signals}, 32'h2);
        cyc();
        ret = 1'b1;
        #1;
        check_val("ret_sel", {28'd0, sel_signals}, 32'h8);
        cyc();
        idle_inputs();
        #1;
        check_val("ret_top", {18'd0, ret_addr}, 32'h0);
        check_val("ret_no_unf", {31'd0, stack_underflow}, 32'h0);

        // ret on empty stack
        ret = 1'b1;
        #1;
        check_val("unf_sel", {28'd0, sel_signals}, 32'h8);
        cyc();
        idle_inputs();
        #1;
        check_val("unf_flag", {31'd0, stack_underflow}, 32'h1);
        check_val("unf_top", {18'd0, ret_addr}, 32'h0);
        cyc();
        check_val("unf_sticky", {31'd0, stack_underflow}, 32'h1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        check_val("unf_clr", {31'd0, stack_underflow}, 32'h0);

        // interrupt with simultaneous call: interrupt wins, only int_ret_addr pushed
        int_req = 1'b1; int_ret_addr = 14'h0200; call = 1'b1; call_ret_addr = 14'h0555;
        #1;
        check_val("irq_sel", {28'd0, sel_signals}, 32'h4);
        cyc();
        idle_inputs();
        #1;
        check_val("irq_ack", {31'd0, int_ack}, 32'h1);
        check_val("irq_en", {31'd0, int_enable}, 32'h0);
        check_val("irq_top", {18'd0, ret_addr}, 32'h0200);
        cyc();
        check_val("irq_ack_pulse", {31'd0, int_ack}, 32'h0);
        int_req = 1'b1;
        #1;
        check_val("isr_nonest_sel", {28'd0, sel_signals}, 32'h2);
        cyc();
        check_val("isr_nonest_en", {31'd0, int_enable}, 32'h0);
        check_val("isr_nonest_ack", {31'd0, int_ack}, 32'h0);
        reti = 1'b1;
        #1;
        check_val("reti_sel", {28'd0, sel_signals}, 32'h8);
        cyc();
        reti = 1'b0;
        #1;
        check_val("reti_en", {31'd0, int_enable}, 32'h1);
        check_val("reti_top", {18'd0, ret_addr}, 32'h0);
        check_val("held_irq_sel", {28'd0, sel_signals}, 32'h4);
        cyc();
        idle_inputs();
        #1;
        check_val("held_irq_ack", {31'd0, int_ack}, 32'h1);
        check_val("held_irq_top", {18'd0, ret_addr}, 32'h0200);
        reti = 1'b1;
        cyc();
        idle_inputs();
        #1;
        check_val("held_reti_en", {31'd0, int_enable}, 32'h1);

        // stall freezes everything
        call = 1'b1; call_ret_addr = 14'h0AAA;
        cyc();
        idle_inputs();
        stall = 1'b1; call = 1'b1; ret = 1'b1; int_req = 1'b1; call_ret_addr = 14'h0BBB;
        #1;
        check_val("stall_sel", {28'd0, sel_signals}, 32'h2);
        cyc();
        #1;
        check_val("stall_ack", {31'd0, int_ack}, 32'h0);
        check_val("stall_en", {31'd0, int_enable}, 32'h1);
        check_val("stall_top", {18'd0, ret_addr}, 32'h0AAA);
        idle_inputs();
        // reti in RUN acts as ret
        reti = 1'b1;
        #1;
        check_val("run_reti_sel", {28'd0, sel_signals}, 32'h8);
        cyc();
        idle_inputs();
        #1;
        check_val("run_reti_top", {18'd0, ret_addr}, 32'h0);
        check_val("run_reti_en", {31'd0, int_enable}, 32'h1);

        // nine calls into an eight-deep stack
        for (int i = 0; i < 9; i++) begin
            call = 1'b1; call_ret_addr = 14'(14'h0100 + i);
            #1;
            check_val($sformatf("fill%0d_sel", i), {28'd0, sel_signals}, 32'h1);
            cyc();
            if (i == 7) check_val("fill8_ovf", {31'd0, stack_overflow}, 32'h0);
        end
        idle_inputs();
        #1;
        check_val("ovf_flag", {31'd0, stack_overflow}, 32'h1);
        check_val("ovf_top", {18'd0, ret_addr}, 32'h0107);
        ret = 1'b1;
        cyc();
        idle_inputs();
        #1;
        check_val("ovf_pop_top", {18'd0, ret_addr}, 32'h0106);

        // ret with simultaneous call: pop only
        ret = 1'b1; call = 1'b1; call_ret_addr = 14'h03FF;
        #1;
        check_val("ret_call_sel", {28'd0, sel_signals}, 32'h8);
        cyc();
        idle_inputs();
        #1;
        check_val("ret_call_top", {18'd0, ret_addr}, 32'h0105);

        // enter ISR with a loaded stack, then reset
        int_req = 1'b1; int_ret_addr = 14'h0222;
        cyc();
        idle_inputs();
        #1;
        check_val("isr2_top", {18'd0, ret_addr}, 32'h0222);
        reset = 1'b1; call = 1'b1; int_req = 1'b1; reti = 1'b1;
        #1;
        check_val("midrst_sel", {28'd0, sel_signals}, 32'h2);
        cyc();
        idle_inputs();
        #1;
        check_val("midrst_en", {31'd0, int_enable}, 32'h1);
        check_val("midrst_ovf", {31'd0, stack_overflow}, 32'h0);
        check_val("midrst_unf", {31'd0, stack_underflow}, 32'h0);
        check_val("midrst_ack", {31'd0, int_ack}, 32'h0);
        check_val("midrst_top", {18'd0, ret_addr}, 32'h0);
        ret = 1'b1;
        cyc();
        idle_inputs();
        #1;
        check_val("midrst_empty", {31'd0, stack_underflow}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_cntr_sel_ctrl.md
PROG_CNTR_SEL_CTRL -- requirements
Module: prog_cntr_sel_ctrl

Interface
REQ-001 Parameter: STACK_DEPTH, default 8, number of return-address stack entries (power of two, 2..16).
REQ-002 Parameter: ADDR_W, default 14, program-address width.
REQ-003 clock  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  pipeline stall; no state change this cycle.
REQ-006 branch_taken  in  1  resolved taken branch/jump this cycle.
REQ-007 call  in  1  call instruction this cycle; push call_ret_addr, redirect to branch target.
REQ-008 ret  in  1  return instruction this cycle; pop, redirect to ret_addr.
REQ-009 reti  in  1  return-from-interrupt this cycle; pop, redirect to ret_addr, exit ISR.
REQ-010 int_req  in  1  level-sensitive interrupt request.
REQ-011 call_ret_addr  in  ADDR_W  address pushed on call.
REQ-012 int_ret_addr  in  ADDR_W  address pushed on interrupt entry (next instruction to execute).
REQ-013 sel_signals  out  4  one-hot PC-source select: bit0 branch target, bit1 next PC, bit2 interrupt vector, bit3 return address.
REQ-014 ret_addr  out  ADDR_W  current top-of-stack entry.
REQ-015 int_enable  out  1  high when interrupts may be taken.
REQ-016 int_ack  out  1  registered one-cycle pulse, cycle after interrupt entry.
REQ-017 stack_overflow  out  1  sticky error flag.
REQ-018 stack_underflow  out  1  sticky error flag.

Function
REQ-019 sel_signals SHALL be combinational from current inputs and registered state, always exactly one bit set.
REQ-020 Selection priority: reset or stall -> 4'b0010; else interrupt-take -> 4'b0100; else ret or reti -> 4'b1000; else call or branch_taken -> 4'b0001; else 4'b0010.
REQ-021 Interrupt-take condition: int_req & int_enable & !stall & !reset.
REQ-022 FSM states RUN (int_enable=1) and ISR (int_enable=0); RUN->ISR on interrupt-take; ISR->RUN on reti & !stall; no other transitions.
REQ-023 reti in RUN state SHALL behave exactly as ret (pop, select 4'b1000, stay RUN).
REQ-024 int_req in ISR SHALL be ignored (no nesting); held request is taken in first RUN cycle after reti.
REQ-025 Stack: count register 0..STACK_DEPTH; push writes entry[count], count+1; pop count-1.
REQ-026 ret_addr = entry[count-1] when count>0, else all zeros; updates the cycle after push/pop.
REQ-027 Push sources: interrupt-take pushes int_ret_addr; else call pushes call_ret_addr; at most one push per cycle.
REQ-028 Interrupt-take with simultaneous call/ret/reti/branch_taken: interrupt wins; other requests dropped (no push/pop for them).
REQ-029 ret/reti with simultaneous call or branch_taken: pop only, call push suppressed.
REQ-030 Push when count==STACK_DEPTH: write dropped, count held, stack_overflow set; selection unaffected.
REQ-031 Pop when count==0: count held at 0, stack_underflow set; selection still 4'b1000, ret_addr 0.
REQ-032 stall SHALL freeze count, entries, FSM state, error flags; int_ack driven 0.
REQ-033 Error flags cleared only by reset.

Reset
REQ-034 On reset: count=0, FSM=RUN, int_enable=1, int_ack=0, stack_overflow=0, stack_underflow=0, sel_signals=4'b0010, ret_addr=0; entries need not be cleared.
REQ-035 Reset asserted mid-ISR or mid-stack-use SHALL discard all state in that cycle regardless of other inputs.

Verification
REQ-036 call with call_ret_addr=14'h0123, then ret two cycles later -> sel 0001 on call cycle, ret_addr=0x0123 next cycle, sel 1000 on ret, count back to 0.
REQ-037 int_req=1 in RUN with int_ret_addr=0x0200 and call=1 same cycle -> sel 0100, only 0x0200 pushed, int_ack pulse next cycle, int_enable=0; reti later -> sel 1000, int_enable=1.
REQ-038 9 consecutive calls (depth 8) -> 9th sets stack_overflow, count stays 8, ret_addr equals 8th pushed value.
REQ-039 ret with empty stack -> stack_underflow=1, sel 1000, ret_addr=0, count=0.
REQ-040 stall=1 with call, ret, int_req asserted -> sel 0010, no state change, int_ack=0.
REQ-041 reset asserted while in ISR with count=3 -> next cycle count=0, int_enable=1, flags 0, sel 0010.
